// File: rtl/lmc_pkg.sv
// -----------------------------------------------------------------------------
// lmc_pkg
// Shared definitions for the LMC CPU and its host-side program loader.
//   - loader_state_t : state encoding of the program loader FSM
//   - LMC_ADDR_WIDTH / LMC_DATA_WIDTH : program memory geometry
//   - instruction bit-field positions of the 12-bit LMC instruction word
// -----------------------------------------------------------------------------
package lmc_pkg;

   localparam int LMC_ADDR_WIDTH = 4;
   localparam int LMC_DATA_WIDTH = 12;

   // Instruction word layout
   localparam int LMC_RAM2_WE_BIT = 11;
   localparam int LMC_ACC_WE_BIT  = 10;
   localparam int LMC_OUT_BIT     = 9;
   localparam int LMC_MUX_SEL_HI  = 8;
   localparam int LMC_MUX_SEL_LO  = 7;
   localparam int LMC_JMP_BIT     = 6;
   localparam int LMC_JMPZ_BIT    = 5;
   localparam int LMC_JMPP_BIT    = 4;
   localparam int LMC_TARGET_HI   = 3;
   localparam int LMC_TARGET_LO   = 0;

   // CHECK and ERROR are only reachable when the checksum feature is built in.
   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_CLEAR  = 4'd1,
      ST_RECV   = 4'd2,
      ST_SETUP  = 4'd3,
      ST_STROBE = 4'd4,
      ST_HOLD   = 4'd5,
      ST_CHECK  = 4'd6,
      ST_DONE   = 4'd7,
      ST_ERROR  = 4'd8
   } loader_state_t;

endpackage

// File: rtl/lmc_we_strobe.sv
// -----------------------------------------------------------------------------
// lmc_we_strobe
// Produces a write-enable pulse exactly WE_PULSE clock cycles wide, starting
// on the clock edge where start is sampled high.
//   timer555    : clock
//   reset_count : asynchronous active-high reset (abandons a pulse in flight)
//   start       : begin a pulse
//   we          : registered write-enable pulse
//   done        : high during the final cycle of the pulse
// -----------------------------------------------------------------------------
module lmc_we_strobe
   import lmc_pkg::*;
#(
   parameter int WE_PULSE = 2
) (
   input  logic timer555,
   input  logic reset_count,
   input  logic start,
   output logic we,
   output logic done
);

   localparam int CW = (WE_PULSE > 1) ? $clog2(WE_PULSE) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WE_PULSE - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          we_reg;
   logic [CW-1:0] count_reg;

   // count_reg holds the number of pulse cycles remaining after the current one
   always_ff @(posedge timer555 or posedge reset_count) begin
      if (reset_count) begin
         we_reg    <= 1'b0;
         count_reg <= '0;
      end else if (start) begin
         we_reg    <= 1'b1;
         count_reg <= CNT_INIT;
      end else if (we_reg) begin
         if (count_reg == '0) begin
            we_reg <= 1'b0;
         end else begin
            count_reg <= count_reg - CNT_ONE;
         end
      end
   end

   assign we   = we_reg;
   assign done = we_reg && (count_reg == '0);

endmodule

// File: rtl/lmc_program_loader.sv
// -----------------------------------------------------------------------------
// lmc_program_loader
// Host-side writer for the LMC program memory. Instruction words arrive on a
// valid/ready stream and are written in order from address 0, each with a
// setup / strobe / hold sequence. The CPU is held in reset while loading and
// released when the load completes.
//
// Ports:
//   timer555      : clock
//   reset_count   : asynchronous active-high reset
//   load_start    : begin a load (honoured in IDLE, DONE, ERROR only)
//   word_valid    : host word available
//   word_data     : host instruction word
//   word_last     : marks the final program word
//   word_ready    : loader accepts the word this cycle
//   prog_addr     : program memory write address
//   prog_data     : program memory write data
//   prog_we       : write strobe (memory captures on rising edge)
//   cpu_hold      : CPU held in reset
//   load_done     : load finished, CPU released
//   load_overflow : memory filled without word_last
//   load_error    : checksum mismatch
//   word_count    : words written in the current / last load
//
// Build option: LOADER_CHECKSUM_EN adds a trailing checksum word (sum of all
// program words mod 2**DATA_WIDTH) checked in a CHECK state; a mismatch ends
// in ERROR with the CPU still held. Without it load_error is tied low.
// -----------------------------------------------------------------------------
module lmc_program_loader
   import lmc_pkg::*;
#(
   parameter int ADDR_WIDTH = LMC_ADDR_WIDTH,
   parameter int DATA_WIDTH = LMC_DATA_WIDTH,
   parameter int WE_PULSE   = 2
) (
   input  logic                  timer555,
   input  logic                  reset_count,
   input  logic                  load_start,
   input  logic                  word_valid,
   input  logic [DATA_WIDTH-1:0] word_data,
   input  logic                  word_last,
   output logic                  word_ready,
   output logic [ADDR_WIDTH-1:0] prog_addr,
   output logic [DATA_WIDTH-1:0] prog_data,
   output logic                  prog_we,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_overflow,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

   loader_state_t         state_reg;
   logic [ADDR_WIDTH-1:0] prog_addr_reg;
   logic [DATA_WIDTH-1:0] prog_data_reg;
   logic                  last_reg;
   logic                  word_ready_reg;
   logic                  cpu_hold_reg;
   logic                  load_done_reg;
   logic                  load_overflow_reg;
   logic [ADDR_WIDTH:0]   word_count_reg;
`ifdef LOADER_CHECKSUM_EN
   logic                  load_error_reg;
   logic [DATA_WIDTH-1:0] checksum_reg;
`endif

   logic strobe_start;
   logic strobe_we;
   logic strobe_done;

   // The strobe fires on the edge leaving SETUP, so prog_we is high for
   // exactly the STROBE cycles and falls on the edge entering HOLD.
   assign strobe_start = (state_reg == ST_SETUP);

   lmc_we_strobe #(
      .WE_PULSE (WE_PULSE)
   ) u_we_strobe (
      .timer555    (timer555),
      .reset_count (reset_count),
      .start       (strobe_start),
      .we          (strobe_we),
      .done        (strobe_done)
   );

   always_ff @(posedge timer555 or posedge reset_count) begin
      if (reset_count) begin
         state_reg         <= ST_IDLE;
         prog_addr_reg     <= '0;
         prog_data_reg     <= '0;
         last_reg          <= 1'b0;
         word_ready_reg    <= 1'b0;
         cpu_hold_reg      <= 1'b0;
         load_done_reg     <= 1'b0;
         load_overflow_reg <= 1'b0;
         word_count_reg    <= '0;
`ifdef LOADER_CHECKSUM_EN
         load_error_reg    <= 1'b0;
         checksum_reg      <= '0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (load_start) begin
                  state_reg         <= ST_CLEAR;
                  cpu_hold_reg      <= 1'b1;
                  load_done_reg     <= 1'b0;
                  load_overflow_reg <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  load_error_reg    <= 1'b0;
`endif
               end
            end

            ST_CLEAR: begin
               prog_addr_reg  <= '0;
               word_count_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
               checksum_reg   <= '0;
`endif
               word_ready_reg <= 1'b1;
               state_reg      <= ST_RECV;
            end

            ST_RECV: begin
               if (word_valid && word_ready_reg) begin
                  prog_data_reg  <= word_data;
                  last_reg       <= word_last;
                  word_ready_reg <= 1'b0;
                  state_reg      <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               state_reg <= ST_STROBE;
            end

            ST_STROBE: begin
               if (strobe_done) begin
                  state_reg <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               word_count_reg <= word_count_reg + COUNT_ONE;
`ifdef LOADER_CHECKSUM_EN
               checksum_reg   <= checksum_reg + prog_data_reg;
`endif
               if (last_reg || (prog_addr_reg == LAST_ADDR)) begin
                  // A final word landing on the top address is a normal end.
                  if (!last_reg) begin
                     load_overflow_reg <= 1'b1;
                  end
`ifdef LOADER_CHECKSUM_EN
                  word_ready_reg <= 1'b1;
                  state_reg      <= ST_CHECK;
`else
                  cpu_hold_reg   <= 1'b0;
                  load_done_reg  <= 1'b1;
                  state_reg      <= ST_DONE;
`endif
               end else begin
                  prog_addr_reg  <= prog_addr_reg + ADDR_ONE;
                  word_ready_reg <= 1'b1;
                  state_reg      <= ST_RECV;
               end
            end

`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
               // checksum_reg already includes the last program word (HOLD).
               if (word_valid && word_ready_reg) begin
                  word_ready_reg <= 1'b0;
                  if (word_data == checksum_reg) begin
                     cpu_hold_reg  <= 1'b0;
                     load_done_reg <= 1'b1;
                     state_reg     <= ST_DONE;
                  end else begin
                     load_error_reg <= 1'b1;
                     state_reg      <= ST_ERROR;
                  end
               end
            end
`endif

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign word_ready    = word_ready_reg;
   assign prog_addr     = prog_addr_reg;
   assign prog_data     = prog_data_reg;
   assign prog_we       = strobe_we;
   assign cpu_hold      = cpu_hold_reg;
   assign load_done     = load_done_reg;
   assign load_overflow = load_overflow_reg;
   assign word_count    = word_count_reg;
`ifdef LOADER_CHECKSUM_EN
   assign load_error    = load_error_reg;
`else
   assign load_error    = 1'b0;
`endif

endmodule

// File: tb/tb_lmc_program_loader.sv
// -----------------------------------------------------------------------------
// tb_lmc_program_loader
// Directed test of lmc_program_loader: reset state, single word, back-to-back
// stream, overflow, backpressure, ignored load_start, reset mid-strobe and
// (with LOADER_CHECKSUM_EN) checksum match / mismatch.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lmc_program_loader;

   logic        timer555    = 1'b0;
   logic        reset_count = 1'b1;
   logic        load_start  = 1'b0;
   logic        word_valid  = 1'b0;
   logic [11:0] word_data   = 12'h000;
   logic        word_last   = 1'b0;
   logic        word_ready;
   logic [3:0]  prog_addr;
   logic [11:0] prog_data;
   logic        prog_we;
   logic        cpu_hold;
   logic        load_done;
   logic        load_overflow;
   logic        load_error;
   logic [4:0]  word_count;

   lmc_program_loader #(
      .ADDR_WIDTH (4),
      .DATA_WIDTH (12),
      .WE_PULSE   (2)
   ) dut (
      .timer555      (timer555),
      .reset_count   (reset_count),
      .load_start    (load_start),
      .word_valid    (word_valid),
      .word_data     (word_data),
      .word_last     (word_last),
      .word_ready    (word_ready),
      .prog_addr     (prog_addr),
      .prog_data     (prog_data),
      .prog_we       (prog_we),
      .cpu_hold      (cpu_hold),
      .load_done     (load_done),
      .load_overflow (load_overflow),
      .load_error    (load_error),
      .word_count    (word_count)
   );

   always #5 timer555 = ~timer555;

   int n_assert = 0;
   int n_fail   = 0;

   logic [11:0] words [0:16];

   // ---------------- write monitor (reads DUT outputs only) ----------------
   int          ready_cnt  = 0;
   int          stable_err = 0;
   int          nw         = 0;
   int          we_w       = 0;
   logic [3:0]  wr_addr [0:63];
   logic [11:0] wr_data [0:63];
   int          wr_w    [0:63];
   logic        prev_we   = 1'b0;
   logic [3:0]  prev_addr = 4'h0;
   logic [11:0] prev_data = 12'h000;
   logic [3:0]  cur_addr  = 4'h0;
   logic [11:0] cur_data  = 12'h000;

   always @(negedge timer555) begin
      if (word_ready) ready_cnt++;
      if ((prog_we || prev_we) && ((prog_addr !== prev_addr) || (prog_data !== prev_data)))
         stable_err++;
      if (prog_we) begin
         we_w++;
         cur_addr = prog_addr;
         cur_data = prog_data;
      end else if (we_w > 0) begin
         if (nw < 64) begin
            wr_addr[nw] = cur_addr;
            wr_data[nw] = cur_data;
            wr_w[nw]    = we_w;
            nw++;
         end
         we_w = 0;
      end
      prev_we   = prog_we;
      prev_addr = prog_addr;
      prev_data = prog_data;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; leaves at a falling edge.
   task automatic pulse_start();
      load_start = 1'b1;
      @(negedge timer555);
      load_start = 1'b0;
   endtask

   // Stream words[0..n-1] with word_valid held high; word_last on index last_idx.
   task automatic stream(input int n, input int last_idx, input int budget, output int acc);
      int cyc;
      acc = 0;
      cyc = 0;
      word_valid = 1'b1;
      word_data  = words[0];
      word_last  = (last_idx == 0);
      while (acc < n && cyc < budget) begin
         if (word_ready) begin
            acc++;
            @(negedge timer555);
            cyc++;
            if (acc < n) begin
               word_data = words[acc];
               word_last = (last_idx == acc);
            end else begin
               word_valid = 1'b0;
               word_last  = 1'b0;
            end
         end else begin
            @(negedge timer555);
            cyc++;
         end
      end
      word_valid = 1'b0;
      word_last  = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (load_done) begin
            ok = 1'b1;
            break;
         end
         @(negedge timer555);
      end
   endtask

   function automatic logic [31:0] all_outputs();
      return {5'd0, prog_addr, prog_data, prog_we, word_ready, cpu_hold,
              load_done, load_overflow, load_error, word_count};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int  acc;
      int  base;
      int  r0;
      int  s0;
      int  errs;
      bit  ok;

      // Reset state
      @(negedge timer555);
      @(negedge timer555);
      check("reset_outputs", all_outputs(), 32'h0);
      reset_count = 1'b0;
      @(negedge timer555);
      @(negedge timer555);
      check("idle_outputs", all_outputs(), 32'h0);

      // Single word 12'h40A
      pulse_start();
      check("single_hold_early", cpu_hold, 1);
      base = nw;
      words[0] = 12'h40A;
      stream(1, 0, 20, acc);
      check("single_accepted", acc, 1);
      wait_done(30, ok);
      check("single_done_seen", ok, 1);
      check("single_nwrites", nw - base, 1);
      check("single_addr", wr_addr[base], 4'h0);
      check("single_data", wr_data[base], 12'h40A);
      check("single_we_width", wr_w[base], 2);
      check("single_cpu_hold", cpu_hold, 0);
      check("single_word_count", word_count, 1);
      check("single_prog_we", prog_we, 0);
      check("single_overflow", load_overflow, 0);
      $display("single: wrote %0h at addr %0h width %0d", wr_data[base], wr_addr[base], wr_w[base]);

      // Back-to-back stream 1,2,3 (last)
      pulse_start();
      check("b2b_done_cleared", load_done, 0);
      base = nw;
      r0 = ready_cnt;
      s0 = stable_err;
      words[0] = 12'h001;
      words[1] = 12'h002;
      words[2] = 12'h003;
      stream(3, 2, 60, acc);
      wait_done(30, ok);
      check("b2b_done_seen", ok, 1);
      check("b2b_accepted", acc, 3);
      check("b2b_nwrites", nw - base, 3);
      errs = 0;
      for (int i = 0; i < 3; i++) begin
         if (wr_addr[base + i] !== 4'(i)) errs++;
         if (wr_data[base + i] !== 12'(i + 1)) errs++;
         if (wr_w[base + i] != 2) errs++;
      end
      check("b2b_write_errors", errs, 0);
      check("b2b_ready_cycles", ready_cnt - r0, 3);
      check("b2b_stable", stable_err - s0, 0);
      check("b2b_word_count", word_count, 3);
      $display("b2b: %0d words written, ready high %0d cycles", nw - base, ready_cnt - r0);

      // Overflow: 17 words, no word_last
      pulse_start();
      base = nw;
      for (int i = 0; i < 17; i++) words[i] = 12'(12'h100 + i);
      stream(17, -1, 150, acc);
      check("ovf_accepted", acc, 16);
      check("ovf_nwrites", nw - base, 16);
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         if (wr_addr[base + i] !== 4'(i)) errs++;
         if (wr_data[base + i] !== 12'(12'h100 + i)) errs++;
      end
      check("ovf_write_errors", errs, 0);
      check("ovf_flag", load_overflow, 1);
      check("ovf_word_count", word_count, 16);
      check("ovf_word_ready", word_ready, 0);
      check("ovf_load_done", load_done, 1);
      check("ovf_cpu_hold", cpu_hold, 0);
      check("ovf_last_addr", prog_addr, 4'hF);
      $display("overflow: %0d words accepted, word_count %0d", acc, word_count);

      // Backpressure in RECV
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (word_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge timer555);
      end
      check("bp_ready_seen", ok, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge timer555);
         check("bp_word_ready", word_ready, 1);
         check("bp_prog_we", prog_we, 0);
         check("bp_cpu_hold", cpu_hold, 1);
      end
      $display("backpressure: held in RECV for 5 cycles");

      // First word of a load, then load_start in RECV must be ignored
      words[0] = 12'h111;
      stream(1, -1, 20, acc);
      check("bp_accepted", acc, 1);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (word_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge timer555);
      end
      check("bp_back_in_recv", ok, 1);
      pulse_start();
      @(negedge timer555);
      @(negedge timer555);
      check("ignored_start_addr", prog_addr, 4'h1);
      check("ignored_start_count", word_count, 1);

      // Reset in the middle of the second write's strobe
      words[0] = 12'h222;
      stream(1, -1, 20, acc);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (prog_we) begin
            ok = 1'b1;
            break;
         end
         @(negedge timer555);
      end
      check("rst_strobe_seen", ok, 1);
      check("rst_strobe_addr", prog_addr, 4'h1);
      reset_count = 1'b1;
      #1;
      check("rst_mid_strobe", all_outputs(), 32'h0);
      @(negedge timer555);
      reset_count = 1'b0;
      @(negedge timer555);
      check("rst_idle_after", all_outputs(), 32'h0);
      $display("reset mid-strobe: outputs cleared");

      // Restart after reset begins again at address 0
      pulse_start();
      base = nw;
      words[0] = 12'h0AB;
      stream(1, 0, 20, acc);
      wait_done(30, ok);
      check("restart_done_seen", ok, 1);
      check("restart_nwrites", nw - base, 1);
      check("restart_addr", wr_addr[base], 4'h0);
      check("restart_data", wr_data[base], 12'h0AB);
      check("restart_word_count", word_count, 1);
      $display("restart: wrote %0h at addr %0h", wr_data[base], wr_addr[base]);

`ifdef LOADER_CHECKSUM_EN
      // Checksum match: 800 + 900 = 1100 -> 100 mod 2**12
      pulse_start();
      words[0] = 12'h800;
      words[1] = 12'h900;
      words[2] = 12'h100;
      stream(3, 1, 60, acc);
      wait_done(30, ok);
      check("csum_ok_done_seen", ok, 1);
      check("csum_ok_accepted", acc, 3);
      check("csum_ok_error", load_error, 0);
      check("csum_ok_cpu_hold", cpu_hold, 0);
      check("csum_ok_word_count", word_count, 2);
      $display("checksum match: load_done %0d", load_done);

      // Checksum mismatch
      pulse_start();
      words[2] = 12'h101;
      stream(3, 1, 60, acc);
      repeat (5) @(negedge timer555);
      check("csum_bad_accepted", acc, 3);
      check("csum_bad_error", load_error, 1);
      check("csum_bad_cpu_hold", cpu_hold, 1);
      check("csum_bad_load_done", load_done, 0);
      check("csum_bad_word_ready", word_ready, 0);
      $display("checksum mismatch: load_error %0d", load_error);
`else
      check("no_csum_error", load_error, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
